// File: rtl/byte_mem_ctrl.sv
// Byte-banked memory controller: four 8-bit banks with an unaligned 4-byte registered
// read every cycle, plus a serial byte/halfword/word write FSM reporting done and error.
module byte_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [1:0]  write,
    input  logic [7:0]  d3,
    input  logic [7:0]  d2,
    input  logic [7:0]  d1,
    input  logic [7:0]  d0,
    output logic [7:0]  q3,
    output logic [7:0]  q2,
    output logic [7:0]  q1,
    output logic [7:0]  q0,
    output logic        done,
    output logic        error
);

    localparam int          ROW_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_BYTE = 2'b01;
    localparam logic [1:0] WR_HALF = 2'b10;
    localparam logic [1:0] WR_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Bytes spanned by an access; a plain read (write code 00) spans all four lanes
    function automatic logic [2:0] access_len(input logic [1:0] wr);
        logic [2:0] len;
        case (wr)
            WR_BYTE: len = 3'd1;
            WR_HALF: len = 3'd2;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

    // Misaligned half/word, or any touched byte past the end of storage (33-bit to catch wrap)
    function automatic logic access_invalid(input logic [1:0] wr, input logic [31:0] addr);
        logic [32:0] last;
        logic        misaligned;
        last       = {1'b0, addr} + {30'd0, access_len(wr)} - 33'd1;
        misaligned = ((wr == WR_HALF) && addr[0]) ||
                     ((wr == WR_WORD) && (addr[1:0] != 2'b00));
        return misaligned || (last >= MEM_BYTES);
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [ROW_W+1:0] lat_addr_r;
    logic [1:0]       lat_size_r;
    logic [31:0]      lat_data_r;
    logic [1:0]       byte_cnt_r;

    logic             req_invalid_s;
    logic             last_byte_s;
    logic             latch_en_s;
    logic             cnt_inc_s;
    logic             mem_we_s;
    logic             done_next_s;

    logic [ROW_W+1:0] wr_addr_s;
    logic [1:0]       wr_bank_s;
    logic [ROW_W-1:0] wr_row_s;
    logic [7:0]       wr_byte_s;

    logic [32:0]      rd_addr_s [4];
    logic [7:0]       rd_byte_s [4];

    logic [7:0]       mem_r [0:3][0:DEPTH_WORDS-1];

    assign req_invalid_s = access_invalid(write, address);
    assign last_byte_s   = ({1'b0, byte_cnt_r} == (access_len(lat_size_r) - 3'd1));

    // A valid request is aligned and in range, so the latched low address bits suffice
    assign wr_addr_s = lat_addr_r + {{ROW_W{1'b0}}, byte_cnt_r};
    assign wr_bank_s = wr_addr_s[1:0];
    assign wr_row_s  = wr_addr_s[ROW_W+1:2];
    assign wr_byte_s = lat_data_r[{byte_cnt_r, 3'b000} +: 8];

    for (genvar gi = 0; gi < 4; gi++) begin : g_rd
        assign rd_addr_s[gi] = {1'b0, address} + 33'(gi);
        assign rd_byte_s[gi] = (rd_addr_s[gi] < MEM_BYTES)
                             ? mem_r[rd_addr_s[gi][1:0]][rd_addr_s[gi][ROW_W+1:2]]
                             : 8'h00;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (write == WR_NONE) begin
                    state_next_s = ST_IDLE;
                end else if (req_invalid_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_byte_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (write == WR_NONE) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode; the byte write is suppressed on a reset edge so an abort leaves no partial byte
    always_comb begin
        latch_en_s = 1'b0;
        cnt_inc_s  = 1'b0;
        mem_we_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                latch_en_s = (write != WR_NONE);
            end
            ST_WRITE: begin
                cnt_inc_s = 1'b1;
                mem_we_s  = !rst;
            end
            default: begin
                latch_en_s = 1'b0;
            end
        endcase
        done_next_s = (state_next_s == ST_DONE);
    end

    // Request latch and byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr_r <= '0;
            lat_size_r <= 2'b00;
            lat_data_r <= 32'h0000_0000;
            byte_cnt_r <= 2'd0;
        end else if (latch_en_s) begin
            lat_addr_r <= address[ROW_W+1:0];
            lat_size_r <= write;
            lat_data_r <= {d0, d1, d2, d3};
            byte_cnt_r <= 2'd0;
        end else if (cnt_inc_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
        end
    end

    // Byte write port; storage is intentionally outside the reset domain
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_bank_s][wr_row_s] <= wr_byte_s;
        end
    end

    // Registered read data, done pulse and access error
    always_ff @(posedge clk) begin
        if (rst) begin
            q3    <= 8'h00;
            q2    <= 8'h00;
            q1    <= 8'h00;
            q0    <= 8'h00;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            q3    <= rd_byte_s[0];
            q2    <= rd_byte_s[1];
            q1    <= rd_byte_s[2];
            q0    <= rd_byte_s[3];
            done  <= done_next_s;
            error <= req_invalid_s;
        end
    end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Self-checking bench for byte_mem_ctrl: directed vector table, multi-cycle corner
// sequences and randomized traffic against a byte-array reference model.
`timescale 1ns/1ps
module tb_byte_mem_ctrl;

    localparam int DEPTH = 64;
    localparam int MEMB  = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [1:0]  write;
    logic [7:0]  d3, d2, d1, d0;
    logic [7:0]  q3, q2, q1, q0;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [MEMB];

    typedef struct {
        logic [1:0]  wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic        err;
    } wvec_t;

    wvec_t wtab [11];

    byte_mem_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .write   (write),
        .d3      (d3),
        .d2      (d2),
        .d1      (d1),
        .d0      (d0),
        .q3      (q3),
        .q2      (q2),
        .q1      (q1),
        .q0      (q0),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] initb(input int a);
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [7:0] ref_byte(input longint a);
        return (a < MEMB) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    function automatic logic [31:0] exp_q(input logic [31:0] a);
        longint b = longint'(a);
        return {ref_byte(b), ref_byte(b + 1), ref_byte(b + 2), ref_byte(b + 3)};
    endfunction

    function automatic int size_bytes(input logic [1:0] wr);
        return (wr == 2'b01) ? 1 : (wr == 2'b10) ? 2 : 4;
    endfunction

    function automatic logic exp_err(input logic [1:0] wr, input logic [31:0] a);
        if (wr == 2'b10 && a[0]) return 1'b1;
        if (wr == 2'b11 && a[1:0] != 2'b00) return 1'b1;
        return (longint'(a) + size_bytes(wr) - 1 >= MEMB);
    endfunction

    function automatic int exp_lat(input logic [1:0] wr, input logic [31:0] a);
        if (exp_err(wr, a)) return 1;
        return size_bytes(wr) + 1;
    endfunction

    task automatic model_write(input logic [1:0] wr, input logic [31:0] a, input logic [31:0] data);
        if (!exp_err(wr, a)) begin
            for (int k = 0; k < size_bytes(wr); k++) ref_mem[int'(a) + k] = data[8*k +: 8];
        end
    endtask

    task automatic issue(input logic [1:0] wr, input logic [31:0] a, input logic [31:0] data);
        write   = wr;
        address = a;
        {d0, d1, d2, d3} = data;
    endtask

    // Steps from the request edge until done; lat counts edges, bounded at 20
    task automatic wait_done(input bit scramble, output int lat, output logic err_seen);
        step();
        err_seen = error;
        lat = 1;
        while (!done && lat < 20) begin
            if (scramble) begin
                address = $urandom;
                {d0, d1, d2, d3} = $urandom;
                write = 2'($urandom_range(1, 3));
            end
            step();
            lat++;
        end
    endtask

    task automatic do_write(input logic [1:0] wr, input logic [31:0] a, input logic [31:0] data,
                            input bit scramble, output int lat, output logic err_seen,
                            output logic done_after);
        issue(wr, a, data);
        wait_done(scramble, lat, err_seen);
        step();
        done_after = done;
        write = 2'b00;
        step();
        model_write(wr, a, data);
    endtask

    task automatic check_read(input logic [31:0] a);
        write   = 2'b00;
        address = a;
        step();
        chk($sformatf("read_q@%h", a), {q3, q2, q1, q0}, exp_q(a));
        chk($sformatf("read_err@%h", a), 32'(error), 32'(exp_err(2'b00, a)));
    endtask

    initial begin
        int          lat;
        logic        e;
        logic        da;
        logic [31:0] ra;
        logic [31:0] rdat;
        logic [1:0]  rw;
        logic [31:0] old_q;

        wtab[0]  = '{2'b11, 32'h0000_0010, 32'hDEAD_BEEF, 5, 1'b0};
        wtab[1]  = '{2'b10, 32'h0000_0022, 32'h0000_ABCD, 3, 1'b0};
        wtab[2]  = '{2'b01, 32'h0000_0031, 32'h0000_005A, 2, 1'b0};
        wtab[3]  = '{2'b11, 32'h0000_0013, 32'h1234_5678, 1, 1'b1};
        wtab[4]  = '{2'b10, 32'h0000_0021, 32'h0000_BBBB, 1, 1'b1};
        wtab[5]  = '{2'b11, 32'h0000_00FC, 32'hCAFE_F00D, 5, 1'b0};
        wtab[6]  = '{2'b10, 32'h0000_00FE, 32'h0000_1234, 3, 1'b0};
        wtab[7]  = '{2'b01, 32'h0000_00FF, 32'h0000_0077, 2, 1'b0};
        wtab[8]  = '{2'b11, 32'h0000_0100, 32'h1111_1111, 1, 1'b1};
        wtab[9]  = '{2'b01, 32'h0000_0100, 32'h0000_0022, 1, 1'b1};
        wtab[10] = '{2'b10, 32'hFFFF_FFFE, 32'h0000_3333, 1, 1'b1};

        rst = 1'b1;
        issue(2'b00, 32'h0, 32'h0);
        step();
        step();
        chk("reset_q", {q3, q2, q1, q0}, 32'h0000_0000);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_error", 32'(error), 32'h0);
        rst = 1'b0;

        // Preload every word so the reference model knows the full contents
        for (int w = 0; w < DEPTH; w++) begin
            do_write(2'b11, 32'(4 * w),
                     {initb(4*w+3), initb(4*w+2), initb(4*w+1), initb(4*w)}, 1'b0, lat, e, da);
        end

        for (int i = 0; i < 11; i++) begin
            do_write(wtab[i].wr, wtab[i].addr, wtab[i].data, 1'b0, lat, e, da);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(wtab[i].lat));
            chk($sformatf("vec%0d_error", i), 32'(e), 32'(wtab[i].err));
            chk($sformatf("vec%0d_single_done", i), 32'(da), 32'h0);
            check_read(wtab[i].addr);
            check_read(wtab[i].addr - 32'd2);
        end

        check_read(32'h14);
        address = 32'h10; step();
        chk("word_read_0x10", {q3, q2, q1, q0}, 32'hEFBE_ADDE);
        address = 32'h11; step();
        chk("word_read_0x11", {8'h00, q3, q2, q1}, 32'h00BE_ADDE);
        address = 32'h22; step();
        chk("half_bytes_0x22", {16'h0000, q3, q2}, 32'h0000_CDAB);
        address = 32'h20; step();
        chk("half_untouched_0x20", {16'h0000, q3, q2}, {16'h0000, initb(32), initb(33)});
        address = 32'(MEMB - 2); step();
        chk("edge_read_q", {q3, q2, q1, q0}, 32'h3477_0000);
        chk("edge_read_err", 32'(error), 32'h1);

        // Read-during-write returns the old byte; new bytes appear one read later
        old_q = exp_q(32'h50);
        issue(2'b11, 32'h50, 32'hA1B2_C3D4);
        step();
        chk("rdw_e0", {q3, q2, q1, q0}, old_q);
        step();
        chk("rdw_e1_old", {q3, q2, q1, q0}, old_q);
        step();
        chk("rdw_e2_byte0_new", {q3, q2, q1, q0}, {8'hD4, old_q[23:0]});
        step();
        chk("rdw_no_done_yet", 32'(done), 32'h0);
        step();
        chk("rdw_done", 32'(done), 32'h1);
        write = 2'b00; step(); step();
        model_write(2'b11, 32'h50, 32'hA1B2_C3D4);
        check_read(32'h50);

        // Write held after done: stays in HOLD, no rewrite, no second done
        issue(2'b11, 32'h60, 32'h0102_0304);
        wait_done(1'b0, lat, e);
        chk("hold_first_latency", 32'(lat), 32'd5);
        for (int i = 0; i < 4; i++) begin
            {d0, d1, d2, d3} = $urandom;
            step();
            chk($sformatf("hold_no_done_%0d", i), 32'(done), 32'h0);
        end
        model_write(2'b11, 32'h60, 32'h0102_0304);
        check_read(32'h60);
        do_write(2'b01, 32'h64, 32'h0000_00AB, 1'b0, lat, e, da);
        chk("after_hold_latency", 32'(lat), 32'd2);
        check_read(32'h64);

        // Reset on the second byte of a word write aborts it
        issue(2'b11, 32'h40, 32'h1122_3344);
        step();
        step();
        rst = 1'b1;
        step();
        chk("abort_q", {q3, q2, q1, q0}, 32'h0000_0000);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_error", 32'(error), 32'h0);
        rst = 1'b0;
        write = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("abort_no_done_%0d", i), 32'(done), 32'h0);
        end
        ref_mem[32'h40] = 8'h44;
        check_read(32'h40);
        do_write(2'b01, 32'h45, 32'h0000_0099, 1'b0, lat, e, da);
        chk("after_abort_latency", 32'(lat), 32'd2);
        check_read(32'h44);

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = 32'(MEMB - int'($urandom_range(1, 8)));
                default: ra = $urandom_range(0, MEMB + 3);
            endcase
            if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) < 6) begin
                check_read(ra);
            end else begin
                rw   = 2'($urandom_range(1, 3));
                rdat = $urandom;
                do_write(rw, ra, rdat, 1'b1, lat, e, da);
                chk($sformatf("rnd%0d_latency", it), 32'(lat), 32'(exp_lat(rw, ra)));
                chk($sformatf("rnd%0d_error", it), 32'(e), 32'(exp_err(rw, ra)));
                chk($sformatf("rnd%0d_single_done", it), 32'(da), 32'h0);
                check_read(ra);
                check_read(ra - 32'd3);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_mem_ctrl.md
BYTE_MEM_CTRL -- requirements
Module: byte_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, sets storage size in 32-bit words (4*DEPTH_WORDS bytes).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 address  input  32  byte address for the read port and the write request.
REQ-005 write  input  2  write size: 00 none, 01 byte, 10 halfword, 11 word.
REQ-006 d3,d2,d1,d0  input  8 each  write data; d3 = bits[7:0] ... d0 = bits[31:24].
REQ-007 q3,q2,q1,q0  output  8 each  registered read data; q3 = byte at address, q2 = address+1, q1 = address+2, q0 = address+3.
REQ-008 done  output  1  one-cycle pulse marking completion of a write request.
REQ-009 error  output  1  registered flag for an invalid access.

Function
REQ-010 Storage SHALL be four 8-bit banks; byte address A maps to bank A[1:0], row A>>2; little-endian.
REQ-011 Read SHALL occur every cycle in every state: q3..q0 capture bytes A..A+3 one cycle after address is presented, including unaligned A.
REQ-012 Any read byte at or beyond 4*DEPTH_WORDS SHALL read as 8'h00.
REQ-013 Read-during-write to the same byte SHALL return the old contents.
REQ-014 error SHALL be registered each cycle as: (write==10 and A[0]) or (write==11 and A[1:0]!=0) or (write!=00 and A+size-1 >= 4*DEPTH_WORDS) or (write==00 and A+3 >= 4*DEPTH_WORDS).
REQ-015 FSM states SHALL be IDLE, WRITE, DONE, HOLD.
REQ-016 IDLE: on write!=00, latch address, size and d3..d0 and byte counter=0. If the request is invalid per REQ-014, go to DONE. Otherwise go to WRITE.
REQ-017 WRITE: one byte per cycle, latched byte k to latched address+k (d3 first, then d2, d1, d0). After 1/2/4 bytes for byte/half/word, go to DONE.
REQ-018 The latched request SHALL be used throughout WRITE; input changes during WRITE SHALL be ignored.
REQ-019 DONE: done=1 for exactly this cycle; go to HOLD.
REQ-020 HOLD: stay until write==00, then go to IDLE, preventing re-trigger by a still-asserted write.
REQ-021 An invalid write SHALL modify no byte but SHALL still pulse done (no hang).
REQ-022 Write latency from request cycle to done pulse SHALL be 2/3/5 cycles for byte/half/word, and 1 cycle for an invalid request.
REQ-023 write==00 in IDLE SHALL change no state; reads continue.

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE, done=0, error=0, q3..q0=8'h00, byte counter=0, latches cleared.
REQ-025 Reset during WRITE SHALL abort the request; bytes already written remain, and no done pulse is issued.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-027 Word write 32'hDEADBEEF at 0x10 -> done at cycle 5, error=0. Read 0x10 -> q0..q3=DE,AD,BE,EF. Read 0x11 -> q3=BE, q2=AD, q1=DE.
REQ-028 Half write 32'h0000ABCD at 0x22 -> done at cycle 3. Bytes 0x22=CD, 0x23=AB. Bytes 0x20, 0x21 unchanged.
REQ-029 Word write at 0x13 -> error=1 next cycle, done after 1 cycle, memory at 0x10..0x17 unchanged.
REQ-030 Hold write=11 for 4 cycles after done -> FSM stays in HOLD, no second write, no second done. Drop write to 00 -> IDLE.
REQ-031 Assert rst during the 2nd byte of a word write at 0x40 -> only byte 0x40 modified, done never pulses, outputs zero, FSM in IDLE.
REQ-032 Read address 4*DEPTH_WORDS-2 -> q3,q2 = stored bytes, q1=q0=00, error=1.
